vote_input_conditioner: RTL
===========================

Name: vote_input_conditioner

Overview:
Upstream front-end of the electronic voting machine. It synchronises and debounces the four raw candidate buttons and the mode switch. It enforces one vote per physical press and rejects simultaneous presses. It hands the vote-counting core a clean single-cycle vote pulse with a candidate index, plus a synchronised mode level and a result-select index for display mode.

Parameters:
- DEBOUNCE_CYCLES, 10: consecutive identical synchronised samples required before a debounced level changes; must be >= 1.
- LOCKOUT_CYCLES, 16: post-release dead time in cycles; used only when VOTE_LOCKOUT_EN is defined.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  asynchronous active-low reset; asserted at 0.
- mode_raw  in  1  raw mode switch; 0 = voting, 1 = result display.
- button_raw  in  4  raw candidate buttons; bit i = candidate i.
- mode_sync  out  1  synchronised mode level, not debounced.
- vote_valid  out  1  one-cycle pulse: a vote is accepted.
- vote_id  out  2  candidate index; valid while vote_valid = 1, otherwise holds its last value.
- conflict  out  1  one-cycle pulse: a multi-button press was rejected.
- result_sel  out  2  candidate selected in result mode; level output.
- busy  out  1  1 whenever the FSM is not in IDLE.

Behaviour:
- Reset (async, reset = 0):
  - All synchroniser flops, debounce counters, debounced levels and lockout counter are cleared.
  - FSM goes to IDLE.
  - All outputs are 0.
  - Release of reset is used synchronously.
- Synchroniser: 2-flop chain on each of button_raw[3:0] and mode_raw. mode_sync is the second flop of the mode_raw chain.
- Debounce, per button:
  - The counter (width $clog2(DEBOUNCE_CYCLES+1)) increments while sync != debounced and clears when they are equal.
  - When the counter reaches DEBOUNCE_CYCLES, debounced takes the sync value and the counter clears.
  - Pulses shorter than DEBOUNCE_CYCLES cycles are invisible downstream.
- Latency: let E0 be the first edge that samples button_raw = 1 on a continuous hold. Then:
  - debounced rises at edge E(DEBOUNCE_CYCLES+1);
  - vote_valid is registered high at edge E(DEBOUNCE_CYCLES+2) for exactly one cycle.
- FSM states: IDLE, HOLD, LOCKOUT.
- IDLE, let P = the debounced button vector:
  - P = 0: stay in IDLE.
  - Exactly one bit i set, mode_sync = 0: vote_valid = 1, vote_id = i, go to HOLD.
  - Exactly one bit i set, mode_sync = 1: result_sel <= i, no vote, go to HOLD.
  - Two or more bits set, either mode: conflict = 1, no vote, result_sel unchanged, go to HOLD.
- HOLD:
  - Any further press, including new buttons going high, is ignored.
  - When P = 0: go to LOCKOUT if VOTE_LOCKOUT_EN is defined, otherwise to IDLE.
- LOCKOUT:
  - The counter loads LOCKOUT_CYCLES-1 on entry and decrements each cycle; presses are ignored.
  - At 0: go to IDLE if P = 0, otherwise go to HOLD.
- Mode changes during HOLD or LOCKOUT have no effect until the FSM next evaluates P in IDLE.
- vote_valid and conflict are mutually exclusive and never assert on consecutive cycles.
- Reset asserted mid-debounce or mid-HOLD aborts with no pulse. After reset release, a button already held must still complete a full synchronise + debounce before a vote is accepted.

Optional Feature:
VOTE_LOCKOUT_EN
- Defined: the LOCKOUT state exists as described. It blocks rapid re-votes for LOCKOUT_CYCLES cycles after every release.
- Undefined: the LOCKOUT state, its counter and all use of LOCKOUT_CYCLES are compiled out, and HOLD returns directly to IDLE.

Decomposition:
- Package evm_pkg:
  - NUM_CAND = 4, CAND_ID_W = 2;
  - the FSM state enum (IDLE, HOLD, LOCKOUT);
  - a function returning the popcount / one-hot index of a 4-bit vector.
- Sub-module button_debouncer: 2-flop synchroniser plus debounce counter for one input, parameterised by DEBOUNCE_CYCLES. It is instantiated 4 times; mode uses the synchroniser only.
- The top level holds the FSM and the output registers.

Test Plan:
1. reset = 0 for 10 cycles, release, DEBOUNCE_CYCLES = 10; button_raw = 4'b0100 held 40 cycles -> exactly one vote_valid pulse at edge E12 with vote_id = 2; busy = 1 from E12 until the debounced release; conflict stays 0.
2. button_raw[0] high for 6 cycles, then low -> no vote_valid, no conflict, busy stays 0.
3. button_raw = 4'b0110 rising on the same edge, held 30 cycles -> one conflict pulse at E12, no vote_valid, result_sel stays 0.
4. Hold button 0; 20 cycles later also press button 3; release both -> a single vote with vote_id = 0, nothing for button 3. With VOTE_LOCKOUT_EN defined, a re-press of button 3 within 16 cycles of the release is ignored, and a re-press after that votes id 3.
5. mode_raw = 1, then press button 3 for 30 cycles -> result_sel = 3, no vote_valid; set mode_raw = 0 and press button 1 -> vote_valid with vote_id = 1, result_sel still 3.
6. Press button 2, assert reset at debounce count 5, release reset with button still held -> all outputs 0 during reset; vote_valid (id 2) exactly DEBOUNCE_CYCLES + 2 edges after the first post-reset sampling edge.

Source files
------------

// File: rtl/evm_pkg.sv
// Shared types and helpers for the voting machine front-end.
// Latency: n/a (declarations and a combinational helper only).
// Backpressure: n/a.
package evm_pkg;

    localparam int NUM_CAND  = 4;
    localparam int CAND_ID_W = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HOLD    = 2'd1,
        LOCKOUT = 2'd2
    } vote_state_t;

    // Number of pressed buttons plus the index of the highest pressed one;
    // the index is meaningful only when exactly one button is pressed.
    typedef struct packed {
        logic [2:0]           count;
        logic [CAND_ID_W-1:0] idx;
    } press_info_t;

    function automatic press_info_t decode_press(input logic [NUM_CAND-1:0] vec);
        press_info_t info;
        info.count = '0;
        info.idx   = '0;
        for (int i = 0; i < NUM_CAND; i++) begin
            if (vec[i]) begin
                info.count = info.count + 3'd1;
                info.idx   = CAND_ID_W'(i);
            end
        end
        return info;
    endfunction

endpackage

// File: rtl/button_debouncer.sv
// Two-flop synchroniser plus debounce filter for one raw push button.
// Latency: level follows a stable input DEBOUNCE_CYCLES+1 edges after first sample.
// Backpressure: none; free-running filter.
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic level
);

    localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_a;
    logic             sync_b;
    logic [CNT_W-1:0] cnt;

    // Bring the asynchronous button into the clock domain.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_a <= 1'b0;
            sync_b <= 1'b0;
        end else begin
            sync_a <= din;
            sync_b <= sync_a;
        end
    end

    // Count consecutive disagreeing samples; the level flips on the last one,
    // so any disagreement run shorter than DEBOUNCE_CYCLES is discarded.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt   <= '0;
            level <= 1'b0;
        end else if (sync_b == level) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            level <= sync_b;
            cnt   <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/vote_input_conditioner.sv
// Button/mode conditioner: one vote or conflict pulse per debounced press; optional VOTE_LOCKOUT_EN adds post-release dead time.
// Latency: vote_valid/conflict registered DEBOUNCE_CYCLES+2 edges after the first raw sample of a press.
// Backpressure: none; pulses are single-cycle and unconditional.
module vote_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 10
`ifdef VOTE_LOCKOUT_EN
    ,
    parameter int LOCKOUT_CYCLES  = 16
`endif
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       mode_raw,
    input  logic [3:0] button_raw,
    output logic       mode_sync,
    output logic       vote_valid,
    output logic [1:0] vote_id,
    output logic       conflict,
    output logic [1:0] result_sel,
    output logic       busy
);

    import evm_pkg::*;

    logic                 mode_meta;
    logic                 mode_q;
    logic [NUM_CAND-1:0]  pressed;
    press_info_t          info;

    vote_state_t          state;
    vote_state_t          state_nxt;
    logic                 vote_valid_nxt;
    logic                 conflict_nxt;
    logic [CAND_ID_W-1:0] vote_id_nxt;
    logic [CAND_ID_W-1:0] result_sel_nxt;

`ifdef VOTE_LOCKOUT_EN
    localparam int LOCK_W = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
    logic [LOCK_W-1:0] lock_cnt;
    logic [LOCK_W-1:0] lock_cnt_nxt;
`endif

    // Mode is a level switch; it is synchronised but deliberately not debounced.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mode_meta <= 1'b0;
            mode_q    <= 1'b0;
        end else begin
            mode_meta <= mode_raw;
            mode_q    <= mode_meta;
        end
    end

    assign mode_sync = mode_q;

    for (genvar g = 0; g < NUM_CAND; g++) begin : g_btn
        button_debouncer #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .clk   (clk),
            .reset (reset),
            .din   (button_raw[g]),
            .level (pressed[g])
        );
    end

    assign info = decode_press(pressed);
    assign busy = (state != IDLE);

    // Decide the next state and the next output values; a press is only
    // evaluated in IDLE, so later buttons and mode changes during a hold are ignored.
    always_comb begin
        state_nxt      = state;
        vote_valid_nxt = 1'b0;
        conflict_nxt   = 1'b0;
        vote_id_nxt    = vote_id;
        result_sel_nxt = result_sel;
`ifdef VOTE_LOCKOUT_EN
        lock_cnt_nxt   = lock_cnt;
`endif
        case (state)
            IDLE: begin
                if (info.count == 3'd1) begin
                    if (!mode_q) begin
                        vote_valid_nxt = 1'b1;
                        vote_id_nxt    = info.idx;
                    end else begin
                        result_sel_nxt = info.idx;
                    end
                    state_nxt = HOLD;
                end else if (info.count != 3'd0) begin
                    conflict_nxt = 1'b1;
                    state_nxt    = HOLD;
                end
            end
            HOLD: begin
                if (pressed == '0) begin
`ifdef VOTE_LOCKOUT_EN
                    state_nxt    = LOCKOUT;
                    lock_cnt_nxt = LOCK_W'(LOCKOUT_CYCLES - 1);
`else
                    state_nxt    = IDLE;
`endif
                end
            end
            LOCKOUT: begin
`ifdef VOTE_LOCKOUT_EN
                // A button still down when the dead time ends is treated as
                // the same press, not a new vote.
                if (lock_cnt == '0) begin
                    state_nxt = (pressed == '0) ? IDLE : HOLD;
                end else begin
                    lock_cnt_nxt = lock_cnt - LOCK_W'(1);
                end
`else
                state_nxt = IDLE;
`endif
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            vote_valid <= 1'b0;
            conflict   <= 1'b0;
            vote_id    <= '0;
            result_sel <= '0;
        end else begin
            state      <= state_nxt;
            vote_valid <= vote_valid_nxt;
            conflict   <= conflict_nxt;
            vote_id    <= vote_id_nxt;
            result_sel <= result_sel_nxt;
        end
    end

`ifdef VOTE_LOCKOUT_EN
    // Post-release dead-time counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lock_cnt <= '0;
        end else begin
            lock_cnt <= lock_cnt_nxt;
        end
    end
`endif

endmodule
